// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned RESULT_SRC_W = 2;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned STRB_W       = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [RESULT_SRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RESULT_SRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RESULT_SRC_W-1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} mem_state_t;

  typedef struct packed {
    logic                    reg_write;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    mem_write;
    logic                    mem_read;
    logic [2:0]              funct3;
    logic [REG_W-1:0]        rd;
    logic [XLEN-1:0]         alu_result;
    logic [XLEN-1:0]         write_data;
    logic [XLEN-1:0]         pc_plus4;
  } em_t;

endpackage

// File: rtl/mem_access_if.sv
// Ready/valid data-memory request/response port.
interface mem_access_if;
  import mem_pkg::*;

  logic                dmem_req_valid;
  logic                dmem_req_ready;
  logic                dmem_req_we;
  logic [XLEN-1:0]     dmem_req_addr;
  logic [XLEN-1:0]     dmem_req_wdata;
  logic [STRB_W-1:0]   dmem_req_wstrb;
  logic                dmem_resp_valid;
  logic [XLEN-1:0]     dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

endinterface

// File: rtl/load_store_align.sv
// Store lane replication/strobes, load lane extraction/extension, misalignment detect.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb      = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wstrb     = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{byte_lane[7]}}, byte_lane}
                                     : {24'd0, byte_lane};
      end
      F3_H, F3_HU: begin
        wstrb      = 4'b0011 << offset;
        wdata      = {2{store_data[15:0]}};
        load_data  = (funct3 == F3_H) ? {{16{half_lane[15]}}, half_lane}
                                      : {16'd0, half_lane};
        misaligned = offset[0];
      end
      default: begin
        misaligned = (offset != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M stage: E/M register, data-memory handshake FSM, load/store alignment, M/W register.
module mem_access
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reg_write_e,
  input  logic [RESULT_SRC_W-1:0] result_src_e,
  input  logic                    mem_write_e,
  input  logic                    mem_read_e,
  input  logic [2:0]              funct3_e,
  input  logic [REG_W-1:0]        rd_e,
  input  logic [XLEN-1:0]         alu_result_e,
  input  logic [XLEN-1:0]         write_data_e,
  input  logic [XLEN-1:0]         pc_plus4_e,
  input  logic                    stall_ext,
  input  logic                    flush_m,
  mem_access_if.master            dmem,
  output logic [XLEN-1:0]         alu_result_m,
  output logic [REG_W-1:0]        rd_m,
  output logic                    reg_write_m,
  output logic                    stall_m,
  output logic                    misaligned_m,
  output logic                    reg_write_w,
  output logic [RESULT_SRC_W-1:0] result_src_w,
  output logic [REG_W-1:0]        rd_w,
  output logic [XLEN-1:0]         alu_result_w,
  output logic [XLEN-1:0]         read_data_w,
  output logic [XLEN-1:0]         pc_plus4_w
);

  em_t        em_q;
  em_t        em_in;
  mem_state_t state;
  logic       done_q;
  logic       mem_op, mis, pending, req_valid, accept, complete, em_load;
  logic [XLEN-1:0] load_data;

  load_store_align u_align (
    .funct3     (em_q.funct3),
    .offset     (em_q.alu_result[1:0]),
    .store_data (em_q.write_data),
    .rdata      (dmem.dmem_resp_rdata),
    .wstrb      (dmem.dmem_req_wstrb),
    .wdata      (dmem.dmem_req_wdata),
    .load_data  (load_data),
    .misaligned (mis)
  );

  // done_q marks an M instruction already handed to W while E/M is held upstream
  assign mem_op    = em_q.mem_read | em_q.mem_write;
  assign pending   = mem_op && !mis && !done_q;
  assign req_valid = (state == REQ) || (state == IDLE && pending);
  assign accept    = req_valid && dmem.dmem_req_ready;
  assign complete  = (accept && (em_q.mem_write || dmem.dmem_resp_valid)) ||
                     (state == WAIT_RESP && dmem.dmem_resp_valid);
  assign stall_m      = pending && !complete;
  assign misaligned_m = mem_op && mis && !done_q;
  assign em_load      = !stall_m && !stall_ext;

  assign dmem.dmem_req_valid = req_valid;
  assign dmem.dmem_req_we    = em_q.mem_write;
  assign dmem.dmem_req_addr  = {em_q.alu_result[XLEN-1:2], 2'b00};

  assign alu_result_m = em_q.alu_result;
  assign rd_m         = em_q.rd;
  assign reg_write_m  = em_q.reg_write;

  always_comb begin
    em_in = '{reg_write: reg_write_e, result_src: result_src_e, mem_write: mem_write_e,
              mem_read: mem_read_e, funct3: funct3_e, rd: rd_e, alu_result: alu_result_e,
              write_data: write_data_e, pc_plus4: pc_plus4_e};
    if (flush_m) begin
      em_in.reg_write = 1'b0;
      em_in.mem_write = 1'b0;
      em_in.mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q   <= '0;
      done_q <= 1'b0;
    end else if (em_load) begin
      em_q   <= em_in;
      done_q <= 1'b0;
    end else if (!stall_m) begin
      done_q <= 1'b1;
    end
  end

  // Request handshake FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            if (!dmem.dmem_req_ready)                          state <= REQ;
            else if (em_q.mem_read && !dmem.dmem_resp_valid)   state <= WAIT_RESP;
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready)
            state <= (em_q.mem_read && !dmem.dmem_resp_valid) ? WAIT_RESP : IDLE;
        end
        WAIT_RESP: begin
          if (dmem.dmem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else if (stall_m || done_q) begin
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else begin
      reg_write_w  <= em_q.reg_write && !(mem_op && mis);
      result_src_w <= em_q.result_src;
      rd_w         <= em_q.rd;
      alu_result_w <= em_q.alu_result;
      read_data_w  <= (em_q.mem_read && !mis) ? load_data : '0;
      pc_plus4_w   <= em_q.pc_plus4;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the memory-access stage.
module tb_mem_access;
  import mem_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    reg_write_e, mem_write_e, mem_read_e, stall_ext, flush_m;
  logic [RESULT_SRC_W-1:0] result_src_e;
  logic [2:0]              funct3_e;
  logic [REG_W-1:0]        rd_e;
  logic [XLEN-1:0]         alu_result_e, write_data_e, pc_plus4_e;
  logic [XLEN-1:0]         alu_result_m, alu_result_w, read_data_w, pc_plus4_w;
  logic [REG_W-1:0]        rd_m, rd_w;
  logic                    reg_write_m, stall_m, misaligned_m, reg_write_w;
  logic [RESULT_SRC_W-1:0] result_src_w;

  int checks   = 0;
  int failures = 0;

  mem_access_if dmem ();

  mem_access dut (
    .clk(clk), .rst(rst),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .funct3_e(funct3_e), .rd_e(rd_e), .alu_result_e(alu_result_e),
    .write_data_e(write_data_e), .pc_plus4_e(pc_plus4_e), .stall_ext(stall_ext),
    .flush_m(flush_m), .dmem(dmem),
    .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m), .stall_m(stall_m),
    .misaligned_m(misaligned_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .rd_w(rd_w), .alu_result_w(alu_result_w), .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic rw, input logic [1:0] rs, input logic mw, input logic mr,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4);
    reg_write_e = rw; result_src_e = rs; mem_write_e = mw; mem_read_e = mr;
    funct3_e = f3; rd_e = rd; alu_result_e = alu; write_data_e = wd; pc_plus4_e = pc4;
  endtask

  task automatic nop_e();
    set_e(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall_ext = 1'b0; flush_m = 1'b0;
    nop_e();
    dmem.dmem_req_ready = 1'b1; dmem.dmem_resp_valid = 1'b0; dmem.dmem_resp_rdata = 32'd0;
    tick(); tick();
    chk("rst_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("rst_stall_m", 32'(stall_m), 32'd0);
    chk("rst_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("rst_read_data_w", read_data_w, 32'd0);
    chk("rst_alu_result_m", alu_result_m, 32'd0);
    rst = 1'b0;
    tick();

    // zero-wait lw
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 5'd5, 32'h104, 32'd0, 32'h8);
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_rdata = 32'hDEADBEEF;
    tick(); nop_e(); #1;
    chk("lw0_stall_m", 32'(stall_m), 32'd0);
    chk("lw0_req_valid", 32'(dmem.dmem_req_valid), 32'd1);
    chk("lw0_addr", dmem.dmem_req_addr, 32'h104);
    chk("lw0_we", 32'(dmem.dmem_req_we), 32'd0);
    tick();
    chk("lw0_read_data_w", read_data_w, 32'hDEADBEEF);
    chk("lw0_reg_write_w", 32'(reg_write_w), 32'd1);
    chk("lw0_rd_w", 32'(rd_w), 32'd5);
    dmem.dmem_resp_valid = 1'b0;

    // lb 0x103 with two waiting cycles
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_B, 5'd6, 32'h103, 32'd0, 32'd0);
    tick(); nop_e(); #1;
    chk("lb_stall_c1", 32'(stall_m), 32'd1);
    chk("lb_req_valid_c1", 32'(dmem.dmem_req_valid), 32'd1);
    tick();
    chk("lb_bubble1", 32'(reg_write_w), 32'd0);
    chk("lb_stall_c2", 32'(stall_m), 32'd1);
    chk("lb_req_valid_wait", 32'(dmem.dmem_req_valid), 32'd0);
    tick();
    chk("lb_bubble2", 32'(reg_write_w), 32'd0);
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_rdata = 32'h80112233; #1;
    chk("lb_stall_c3", 32'(stall_m), 32'd0);
    tick();
    chk("lb_read_data_w", read_data_w, 32'hFFFFFF80);
    chk("lb_reg_write_w", 32'(reg_write_w), 32'd1);
    dmem.dmem_resp_valid = 1'b0;

    // lbu same address, zero-wait
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_BU, 5'd6, 32'h103, 32'd0, 32'd0);
    tick(); nop_e(); dmem.dmem_resp_valid = 1'b1; #1;
    chk("lbu_stall", 32'(stall_m), 32'd0);
    tick();
    chk("lbu_read_data_w", read_data_w, 32'h00000080);
    dmem.dmem_resp_valid = 1'b0;

    // sh 0x202 with req_ready low for 3 cycles
    set_e(1'b0, RES_ALU, 1'b1, 1'b0, F3_H, 5'd0, 32'h202, 32'h0000ABCD, 32'd0);
    tick(); nop_e(); dmem.dmem_req_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_valid", 32'(dmem.dmem_req_valid), 32'd1);
      chk("sh_addr", dmem.dmem_req_addr, 32'h200);
      chk("sh_wstrb", 32'(dmem.dmem_req_wstrb), 32'hC);
      chk("sh_wdata", dmem.dmem_req_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(dmem.dmem_req_we), 32'd1);
      chk("sh_stall", 32'(stall_m), 32'd1);
      tick();
    end
    dmem.dmem_req_ready = 1'b1; #1;
    chk("sh_accept_stall", 32'(stall_m), 32'd0);
    chk("sh_accept_valid", 32'(dmem.dmem_req_valid), 32'd1);
    tick();
    chk("sh_after_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("sh_after_reg_write_w", 32'(reg_write_w), 32'd0);

    // sb 0x301
    set_e(1'b0, RES_ALU, 1'b1, 1'b0, F3_B, 5'd0, 32'h301, 32'h12345655, 32'd0);
    tick(); nop_e(); #1;
    chk("sb_wstrb", 32'(dmem.dmem_req_wstrb), 32'h2);
    chk("sb_wdata", dmem.dmem_req_wdata, 32'h55555555);
    chk("sb_stall", 32'(stall_m), 32'd0);
    tick();

    // misaligned lw 0x105, held one extra cycle by stall_ext
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 5'd7, 32'h105, 32'd0, 32'd0);
    tick(); nop_e(); #1;
    chk("mis_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("mis_pulse", 32'(misaligned_m), 32'd1);
    chk("mis_stall", 32'(stall_m), 32'd0);
    stall_ext = 1'b1;
    tick();
    chk("mis_pulse_end", 32'(misaligned_m), 32'd0);
    chk("mis_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("mis_rd_m_held", 32'(rd_m), 32'd7);
    chk("mis_req_valid_held", 32'(dmem.dmem_req_valid), 32'd0);
    stall_ext = 1'b0;
    tick();
    chk("mis_no_replay_w", 32'(reg_write_w), 32'd0);

    // plain ALU op
    set_e(1'b1, RES_ALU, 1'b0, 1'b0, 3'b000, 5'd9, 32'h1234, 32'hFFFF, 32'h44);
    tick(); nop_e(); #1;
    chk("alu_alu_result_m", alu_result_m, 32'h1234);
    chk("alu_rd_m", 32'(rd_m), 32'd9);
    chk("alu_reg_write_m", 32'(reg_write_m), 32'd1);
    chk("alu_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    tick();
    chk("alu_reg_write_w", 32'(reg_write_w), 32'd1);
    chk("alu_alu_result_w", alu_result_w, 32'h1234);
    chk("alu_pc_plus4_w", pc_plus4_w, 32'h44);
    chk("alu_read_data_w", read_data_w, 32'd0);

    // reset during WAIT_RESP, late response ignored
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 5'd10, 32'h100, 32'd0, 32'd0);
    tick(); nop_e(); #1;
    chk("rstw_stall_c1", 32'(stall_m), 32'd1);
    tick();
    chk("rstw_wait_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("rstw_wait_stall", 32'(stall_m), 32'd1);
    rst = 1'b1; #1;
    chk("rstw_stall", 32'(stall_m), 32'd0);
    chk("rstw_reg_write_m", 32'(reg_write_m), 32'd0);
    chk("rstw_alu_result_m", alu_result_m, 32'd0);
    @(negedge clk);
    rst = 1'b0; dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_rdata = 32'hCAFEF00D;
    tick();
    chk("rstw_late_stall", 32'(stall_m), 32'd0);
    chk("rstw_late_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("rstw_late_read_data_w", read_data_w, 32'd0);
    chk("rstw_late_valid", 32'(dmem.dmem_req_valid), 32'd0);
    dmem.dmem_resp_valid = 1'b0;

    // flushed load
    set_e(1'b1, RES_MEM, 1'b0, 1'b1, F3_W, 5'd11, 32'h108, 32'd0, 32'd0);
    flush_m = 1'b1;
    tick(); flush_m = 1'b0; nop_e(); #1;
    chk("flush_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("flush_reg_write_m", 32'(reg_write_m), 32'd0);
    chk("flush_stall", 32'(stall_m), 32'd0);
    tick();
    chk("flush_reg_write_w", 32'(reg_write_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
